// File: rtl/spi_pkg.sv
// spi_pkg: shared widths and receive FIFO entry layout for the 32-bit SPI peripheral
//   SPI_BYTE_W / SPI_WORD_W / SPI_WORD_BYTES : byte and word geometry
//   RX_ENTRY_W, rx_entry_t                   : one FIFO entry = {data, nbytes, last}
package spi_pkg;
    localparam int SPI_BYTE_W     = 8;
    localparam int SPI_WORD_W     = 32;
    localparam int SPI_WORD_BYTES = 4;
    localparam int RX_ENTRY_W     = SPI_WORD_W + 3 + 1;

    typedef struct packed {
        logic [SPI_WORD_W-1:0] data;
        logic [2:0]            nbytes;
        logic                  last;
    } rx_entry_t;
endpackage

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: first-word-fall-through FIFO of packed rx entries
//   clk, reset (async, active-high), clear (sync flush)
//   push/push_data : write request; accepted when not full or when popping in the same cycle
//   pop/pop_data   : head entry is always visible on pop_data; pop consumes it
//   full, empty, level : occupancy status
module rx_word_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [RX_ENTRY_W-1:0] push_data,
    input  logic                  pop,
    output logic [RX_ENTRY_W-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [LW-1:0]         level
);
    logic [RX_ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = level == LW'(DEPTH);
    assign empty    = level == '0;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/spi_rx_word_packer.sv
// spi_rx_word_packer: packs received SPI bytes into 32-bit words and queues them for the host
//   rx_dv/rx_byte : one-cycle byte strobes from the SPI master
//   frame_end     : end of transaction, flushes a partial word tagged last
//   clear         : synchronous flush of accumulator, FIFO and overflow
//   out_valid/out_ready/out_data/out_nbytes/out_last : FWFT host handshake (zeros when empty)
//   overflow      : sticky, a word was dropped on a full FIFO
//   level         : FIFO occupancy
module spi_rx_word_packer
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_dv,
    input  logic [SPI_BYTE_W-1:0]         rx_byte,
    input  logic                          frame_end,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SPI_WORD_W-1:0]         out_data,
    output logic [2:0]                    out_nbytes,
    output logic                          out_last,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    logic [SPI_WORD_W-1:0] acc;
    logic [1:0]            byte_cnt;
    logic [4:0]            lane_shift;
    logic [SPI_WORD_W-1:0] merged;
    logic [2:0]            filled;
    logic                  push_req;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  drop;
    rx_entry_t             push_entry;
    rx_entry_t             head;
    logic [RX_ENTRY_W-1:0] head_raw;

    // MSB-first: lane k sits at bit 24-8k, i.e. shift by 8*(3-k) = {~k,3'b0}.
    assign lane_shift = MSB_FIRST != 0 ? {~byte_cnt, 3'b000} : {byte_cnt, 3'b000};
    assign merged     = acc | (rx_dv ? SPI_WORD_W'(rx_byte) << lane_shift : '0);
    assign filled     = {1'b0, byte_cnt} + {2'b00, rx_dv};

    // A full word and a flush share one push: nbytes is the fill count either way,
    // and last follows frame_end (always 1 for a flush).
    assign push_req   = !clear && (filled == 3'(SPI_WORD_BYTES) || (frame_end && filled != '0));
    assign push_entry = '{data: merged, nbytes: filled, last: frame_end};
    assign pop        = out_valid && out_ready;
    assign drop       = push_req && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (clear || push_req) begin
                acc      <= '0;
                byte_cnt <= '0;
            end else if (rx_dv) begin
                acc      <= merged;
                byte_cnt <= byte_cnt + 1'b1;
            end
            overflow <= clear ? 1'b0 : (overflow || drop);
        end
    end

    rx_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_raw),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign head       = head_raw;
    assign out_valid  = !empty;
    assign out_data   = out_valid ? head.data : '0;
    assign out_nbytes = out_valid ? head.nbytes : '0;
    assign out_last   = out_valid && head.last;
endmodule

// File: tb/tb_spi_rx_word_packer.sv
// tb_spi_rx_word_packer: scoreboard bench driving an MSB-first and an LSB-first packer in parallel
module tb_spi_rx_word_packer;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = '0;
    logic          frame_end = 1'b0;
    logic          clear = 1'b0;
    logic          out_ready = 1'b0;
    logic          mv, lv, ml, ll, mo, lo;
    logic [31:0]   md, ld;
    logic [2:0]    mn, ln;
    logic [LW-1:0] mlev, llev;

    always #5 clk = ~clk;

    spi_rx_word_packer #(.FIFO_DEPTH(D), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte), .frame_end(frame_end),
        .clear(clear), .out_valid(mv), .out_ready(out_ready), .out_data(md), .out_nbytes(mn),
        .out_last(ml), .overflow(mo), .level(mlev)
    );

    spi_rx_word_packer #(.FIFO_DEPTH(D), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte), .frame_end(frame_end),
        .clear(clear), .out_valid(lv), .out_ready(out_ready), .out_data(ld), .out_nbytes(ln),
        .out_last(ll), .overflow(lo), .level(llev)
    );

    typedef struct {
        logic [31:0] dm;
        logic [31:0] dl;
        logic [2:0]  nb;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [31:0] am = '0;
    logic [31:0] al = '0;
    int          cnt = 0;
    logic        ovf = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        exp_t h;
        logic v;
        v = q.size() != 0;
        h.dm = '0; h.dl = '0; h.nb = '0; h.last = 1'b0;
        if (v) h = q[0];
        check("valid_msb", 32'(mv), 32'(v));
        check("valid_lsb", 32'(lv), 32'(v));
        check("level_msb", 32'(mlev), q.size());
        check("level_lsb", 32'(llev), q.size());
        check("ovf_msb", 32'(mo), 32'(ovf));
        check("ovf_lsb", 32'(lo), 32'(ovf));
        check("data_msb", md, h.dm);
        check("data_lsb", ld, h.dl);
        check("nbytes_msb", 32'(mn), 32'(h.nb));
        check("nbytes_lsb", 32'(ln), 32'(h.nb));
        check("last_msb", 32'(ml), 32'(h.last));
        check("last_lsb", 32'(ll), 32'(h.last));
    endtask

    task automatic model_reset();
        q.delete();
        am = '0; al = '0; cnt = 0; ovf = 1'b0;
    endtask

    // One clock: check what the DUTs show now, drive this cycle's inputs, advance the model.
    task automatic step(input logic dv, input logic [7:0] b, input logic fe, input logic clr, input logic rdy);
        logic pop, push;
        exp_t e;
        @(negedge clk);
        check_outputs();
        rx_dv = dv; rx_byte = b; frame_end = fe; clear = clr; out_ready = rdy;
        if (clr) begin
            model_reset();
            return;
        end
        pop = q.size() != 0 && rdy;
        if (dv) begin
            am = am | (32'(b) << (24 - 8 * cnt));
            al = al | (32'(b) << (8 * cnt));
            cnt++;
        end
        push = cnt == 4 || (fe && cnt > 0);
        e.dm = am; e.dl = al; e.nb = 3'(cnt); e.last = fe;
        if (push) begin
            am = '0; al = '0; cnt = 0;
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < D) q.push_back(e);
            else ovf = 1'b1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic fe, input logic rdy_last);
        for (int i = 0; i < 4; i++)
            step(1'b1, w[31-8*i -: 8], fe && i == 3, 1'b0, i == 3 ? rdy_last : 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Full word with frame_end on the last byte; drains one cycle after appearing.
        send_word(32'hDEADBEEF, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Partial word flushed by a lone frame_end, then an empty frame_end.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Fill with out_ready low: the fifth word drops and overflow sticks.
        for (int i = 0; i < 5; i++) send_word(32'hA0B0C0D0 + 32'(i), i == 4, 1'b0);
        idle(2, 1'b0);
        // Push into a full FIFO while popping: no drop.
        send_word(32'h01020304, 1'b1, 1'b1);
        idle(6, 1'b1);

        // Clear mid-word, then a clean word.
        send_word(32'h55667788, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        send_word(32'hCAFEF00D, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Byte and frame_end together on a partial word.
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Asynchronous reset after two bytes of a word.
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1; rx_dv = 1'b0; frame_end = 1'b0; clear = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        send_word(32'h12345678, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Random traffic with occasional clears.
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0);
        idle(8, 1'b1);

        @(negedge clk);
        check_outputs();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_rx_word_packer.md
# spi_rx_word_packer

Receive-side byte-to-word packer for the 32-bit SPI peripheral. Consumes the one-cycle byte-valid pulses from the SPI master's receive port and packs bytes into 32-bit words. Completed words go into a small first-word-fall-through FIFO, which the host side drains with a valid/ready handshake. Partial words are flushed at end of transaction, tagged with their byte count.

## Interface
Parameters:
- FIFO_DEPTH, 4, word entries in the output FIFO; power of two, 2..16
- MSB_FIRST, 1, 1: first received byte lands in out_data[31:24]; 0: first byte lands in out_data[7:0]

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rx_dv  in  1  byte-valid pulse, one cycle per received byte
- rx_byte  in  8  received byte, sampled when rx_dv=1
- frame_end  in  1  one-cycle pulse at end of SPI transaction (chip-select release); flushes the partial word
- clear  in  1  synchronous clear of accumulator, FIFO and overflow
- out_valid  out  1  FIFO head holds a word
- out_ready  in  1  consumer accepts the head word when out_valid=1
- out_data  out  32  head word; unused byte lanes are 0
- out_nbytes  out  3  valid bytes in the head word, 1..4
- out_last  out  1  head word is the final word of its transaction
- overflow  out  1  sticky; a word was dropped because the FIFO was full
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Accumulator: acc[31:0] plus byte_cnt (0..3).
  - rx_dv writes rx_byte into lane byte_cnt.
  - MSB_FIRST=1: lane k is bits [31-8k:24-8k]. MSB_FIRST=0: lane k is bits [8k+7:8k].
- Word push:
  - Full word: rx_dv with byte_cnt=3 pushes {acc with new byte, nbytes=4, last=frame_end}. byte_cnt then returns to 0 and acc to 0.
  - Flush: frame_end with byte_cnt>0 pushes the partial word, nbytes=byte_cnt (+1 if rx_dv in the same cycle), last=1. Unfilled lanes are 0.
  - rx_dv and frame_end in the same cycle: the byte is included first, then the flush happens.
  - frame_end with byte_cnt=0 and no rx_dv pushes nothing. The previously pushed word keeps its last flag.
- FIFO:
  - Pop occurs when out_valid && out_ready.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow is set, and the accumulator still resets.
- clear has priority over rx_dv and frame_end. It empties the FIFO, zeroes acc and byte_cnt, and clears overflow. overflow clears only on clear or reset.
- Outputs when out_valid=0: out_data=0, out_nbytes=0, out_last=0.
- Pointers wrap modulo FIFO_DEPTH. level stays in 0..FIFO_DEPTH.

## Timing
- Reset values: out_valid 0, out_data 0, out_nbytes 0, out_last 0, overflow 0, level 0, acc 0, byte_cnt 0.
- Latency: a push in cycle N gives out_valid=1, with the word on out_data, in cycle N+1 when the FIFO was empty.
- Throughput: sustained one pop per cycle. An rx_dv on every cycle is accepted (one byte per cycle).
- level updates the cycle after a push or pop. A simultaneous push and pop leaves level unchanged.
- overflow asserts the cycle after the dropped push.
- clear in cycle N gives out_valid=0, level=0 and overflow=0 in cycle N+1.
- Reset mid-word or mid-transaction discards all state. No partial flush occurs on reset.

## Structure
- Shared package spi_pkg holds:
  - SPI_BYTE_W=8, SPI_WORD_W=32, SPI_WORD_BYTES=4
  - rx entry packing width 36 = data 32 + nbytes 3 + last 1
- One sub-module, rx_word_fifo:
  - first-word-fall-through, parameterised depth, 36-bit entries
  - ports: push, pop, full, empty, level
- The packer holds the accumulator and overflow logic and instantiates rx_word_fifo.

## Test plan
- MSB_FIRST=1, bytes 0xDE,0xAD,0xBE,0xEF then frame_end on the last byte's cycle -> one word 0xDEADBEEF, nbytes=4, last=1, out_valid at +1 cycle.
- MSB_FIRST=0, same bytes -> 0xEFBEADDE, nbytes=4.
- MSB_FIRST=1, bytes 0x11,0x22 then frame_end alone -> 0x11220000, nbytes=2, last=1. A second frame_end with no bytes pushes nothing.
- out_ready=0, FIFO_DEPTH=4, push 5 full words -> level=4, overflow=1, FIFO holds the first 4 words in order. Pushing when full with out_ready=1 on the same cycle -> no drop.
- 4 bytes, then clear mid-way through the next word -> out_valid=0, level=0, overflow=0. The next 4 bytes form a clean word.
- Assert reset during byte 2 -> all outputs return to reset values. The following 4-byte frame packs correctly from lane 0.
